// File: rtl/equal_pkg.sv
// Shared widths and types for the equality compare path.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional first_diff/any_diff outputs are enabled by EQUAL_FIRST_DIFF_EN.
package equal_pkg;
    localparam int EQ_WIDTH = 32;
    localparam int EQ_IDX_W = $clog2(EQ_WIDTH);

    typedef logic [EQ_WIDTH-1:0] eq_word_t;
    typedef logic [EQ_IDX_W-1:0] eq_idx_t;
endpackage

// File: rtl/equal_reduce8.sv
// 8-bit compare slice: per-bit mismatch plus a slice-equal flag.
// Latency: combinational. Backpressure: none.
// Equality is a balanced 3-level AND tree over the XNORs.
module equal_reduce8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] mismatch,
    output logic       eq
);
    logic [7:0] xn;
    logic [3:0] lvl1;
    logic [1:0] lvl2;

    assign mismatch = a ^ b;
    assign xn       = ~mismatch;

    assign lvl1 = {xn[7] & xn[6], xn[5] & xn[4], xn[3] & xn[2], xn[1] & xn[0]};
    assign lvl2 = {lvl1[3] & lvl1[2], lvl1[1] & lvl1[0]};
    assign eq   = lvl2[1] & lvl2[0];
endmodule

// File: rtl/equal_32.sv
// Registered WIDTH-bit equality comparator with per-bit mismatch mask.
// Latency: 1 cycle from in_valid to out_valid. Backpressure: none, one pair per cycle.
// EQUAL_FIRST_DIFF_EN adds the first_diff priority encoder and any_diff.
module equal_32
    import equal_pkg::*;
#(
    parameter int WIDTH = EQ_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    output logic                     y,
    output logic [WIDTH-1:0]         mismatch
`ifdef EQUAL_FIRST_DIFF_EN
    ,
    output logic [$clog2(WIDTH)-1:0] first_diff,
    output logic                     any_diff
`endif
);
    localparam int NSLICE = WIDTH / 8;
    localparam int IDX_W  = $clog2(WIDTH);

    logic [WIDTH-1:0]  diff;
    logic [NSLICE-1:0] slice_eq;
    logic              eq_all;

    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        equal_reduce8 u_reduce (
            .a        (a[g*8 +: 8]),
            .b        (b[g*8 +: 8]),
            .mismatch (diff[g*8 +: 8]),
            .eq       (slice_eq[g])
        );
    end

    assign eq_all = &slice_eq;

    // Data outputs only move on a capture; out_valid is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= 1'b0;
            mismatch  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y        <= eq_all;
                mismatch <= diff;
            end
        end
    end

`ifdef EQUAL_FIRST_DIFF_EN
    logic [IDX_W-1:0] first_diff_nxt;

    // Scan high to low so the lowest set bit is written last and wins.
    always_comb begin
        first_diff_nxt = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (diff[i]) first_diff_nxt = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_diff <= '0;
        end else if (in_valid) begin
            first_diff <= first_diff_nxt;
        end
    end

    assign any_diff = ~y;
`endif
endmodule

// File: tb/tb_equal_32.sv
// Directed self-checking bench for equal_32 with hand-computed expectations.
// first_diff/any_diff checks are compiled only when EQUAL_FIRST_DIFF_EN is defined.
module tb_equal_32;
    import equal_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     in_valid;
    eq_word_t a_in;
    eq_word_t b_in;
    logic     out_valid;
    logic     y;
    eq_word_t mismatch;
`ifdef EQUAL_FIRST_DIFF_EN
    eq_idx_t  first_diff;
    logic     any_diff;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    equal_32 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a          (a_in),
        .b          (b_in),
        .out_valid  (out_valid),
        .y          (y),
        .mismatch   (mismatch)
`ifdef EQUAL_FIRST_DIFF_EN
        ,
        .first_diff (first_diff),
        .any_diff   (any_diff)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the capturing edge.
    task automatic cycle(input logic v, input eq_word_t av, input eq_word_t bv);
        @(negedge clk);
        in_valid = v;
        a_in     = av;
        b_in     = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input string tag, input logic ev, input logic ey,
                                 input eq_word_t em, input int efd);
        check({tag, "_vld"}, 32'(out_valid), 32'(ev));
        check({tag, "_y"}, 32'(y), 32'(ey));
        check({tag, "_mm"}, mismatch, em);
`ifdef EQUAL_FIRST_DIFF_EN
        check({tag, "_fd"}, 32'(first_diff), 32'(efd));
        check({tag, "_any"}, 32'(any_diff), 32'(~ey));
`else
        if (efd < 0) check({tag, "_fd_arg"}, 32'(efd), 32'd0);
`endif
    endtask

    typedef struct {
        eq_word_t av;
        eq_word_t bv;
        logic     ey;
        eq_word_t em;
        int       efd;
    } vec_t;

    vec_t eq_vecs[5];
    vec_t stream[7];

    initial begin
        eq_vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 0};
        eq_vecs[1] = '{32'h00000000, 32'h00000000, 1'b1, 32'h0, 0};
        eq_vecs[2] = '{32'h00000808, 32'h00000808, 1'b1, 32'h0, 0};
        eq_vecs[3] = '{32'hFF98967F, 32'hFF98967F, 1'b1, 32'h0, 0};
        eq_vecs[4] = '{32'h00000001, 32'h00000001, 1'b1, 32'h0, 0};

        stream[0] = '{32'h11111111, 32'h11111111, 1'b1, 32'h00000000, 0};
        stream[1] = '{32'h11111111, 32'h11111110, 1'b0, 32'h00000001, 0};
        stream[2] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'h00000000, 0};
        stream[3] = '{32'h00000100, 32'h00000000, 1'b0, 32'h00000100, 8};
        stream[4] = '{32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 32'h00000000, 0};
        stream[5] = '{32'h0F0F0000, 32'h0E0F0000, 1'b0, 32'h01000000, 24};
        stream[6] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 32'h00000000, 0};

        // Reset held with live operands: nothing may be captured.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a_in     = 32'h0000F0F0;
        b_in     = 32'h0000FF00;
        repeat (2) @(posedge clk);
        #1;
        expect_result("rst", 1'b0, 1'b0, 32'h0, 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_result("first_cap", 1'b1, 1'b0, 32'h00000FF0, 4);

        foreach (eq_vecs[i]) begin
            cycle(1'b1, eq_vecs[i].av, eq_vecs[i].bv);
            expect_result($sformatf("eq%0d", i), 1'b1, 1'b1, 32'h0, 0);
        end

        cycle(1'b1, 32'hFF98967F, 32'hFB98967F);
        expect_result("bit26", 1'b1, 1'b0, 32'h04000000, 26);

        cycle(1'b1, 32'h00000001, 32'h00000002);
        expect_result("bit0", 1'b1, 1'b0, 32'h00000003, 0);

        // Idle cycle with changed operands: data must hold.
        cycle(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        expect_result("hold", 1'b0, 1'b0, 32'h00000003, 0);

        cycle(1'b1, 32'h80000000, 32'h00000000);
        expect_result("msb", 1'b1, 1'b0, 32'h80000000, 31);

        foreach (stream[i]) begin
            cycle(1'b1, stream[i].av, stream[i].bv);
            expect_result($sformatf("strm%0d", i), 1'b1, stream[i].ey, stream[i].em, stream[i].efd);
        end

        // Asynchronous reset between edges with in_valid still high.
        #1;
        rst_n = 1'b0;
        #1;
        expect_result("async_rst", 1'b0, 1'b0, 32'h0, 0);
        @(posedge clk);
        #1;
        expect_result("rst_hold", 1'b0, 1'b0, 32'h0, 0);

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        expect_result("post_rst", 1'b0, 1'b0, 32'h0, 0);

        cycle(1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF);
        expect_result("msb2", 1'b1, 1'b0, 32'h80000000, 31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
